extend_stream: RTL and testbench
================================

Name: extend_stream

Overview:
- Parametrised, buffered successor to the combinational sign/zero extender.
- Accepts IN_WIDTH-bit operands over a valid/ready stream and extends each one to OUT_WIDTH using a per-operand mode: zero, sign, upper-place or ones.
- Holds results in a DEPTH-entry FIFO and presents them on a valid/ready output stream.
- Sits between operand producers (decode/immediate fetch) and a datapath consumer that may stall.

Parameters:
- IN_WIDTH, 16, input operand width; 1 <= IN_WIDTH < OUT_WIDTH.
- OUT_WIDTH, 32, extended result width.
- DEPTH, 4, FIFO entries; DEPTH >= 2, need not be a power of two.
- CW, $clog2(DEPTH+1), occupancy counter width (derived, not overridden).

Ports:
- iClk  input  1  clock; all state changes on rising edge.
- iRst_n  input  1  reset, asynchronous, active-low.
- iA  input  IN_WIDTH  operand.
- iMode  input  2  00 zero-ext, 01 sign-ext, 10 upper-place, 11 ones-ext.
- iValid  input  1  iA/iMode valid this cycle.
- oReady  output  1  block can accept an operand this cycle.
- oB  output  OUT_WIDTH  extended result at FIFO head.
- oValid  output  1  oB valid.
- iReady  input  1  consumer accepts oB this cycle.
- oCount  output  CW  current FIFO occupancy.
- oFull  output  1  oCount == DEPTH.
- oEmpty  output  1  oCount == 0.

Behaviour:
Reset:
- iRst_n low forces, asynchronously: rd/wr pointers 0, count 0.
- Outputs during and after reset: oValid 0, oEmpty 1, oFull 0, oReady 1, oCount 0, oB 0.
- Memory contents need not be cleared.
- Reset mid-operation discards all stored entries. The first edge after release behaves as from empty.

Extension (combinational, applied at write; the stored value is the extended result):
- 00: upper OUT_WIDTH-IN_WIDTH bits 0, low bits iA.
- 01: upper bits replicate iA[IN_WIDTH-1].
- 10: iA placed in the upper IN_WIDTH bits, lower OUT_WIDTH-IN_WIDTH bits 0.
- 11: upper bits all 1, low bits iA.

Handshake:
- Write occurs when iValid && oReady. oReady = !oFull, with no combinational path from iReady.
- Read occurs when oValid && iReady. oValid = !oEmpty.
- oB = mem[rd_ptr] when oValid, else 0.
- oB and oValid stay stable while oValid && !iReady.
- Latency: an operand written at edge N is visible on oB/oValid after edge N when the FIFO was empty. There is no same-cycle fall-through.

Pointers and count:
- wr_ptr/rd_ptr increment on write/read and wrap from DEPTH-1 to 0.
- count +1 on write only, -1 on read only, unchanged on simultaneous write and read.

Boundaries:
- Full: oReady 0; iValid is ignored and no data is lost or overwritten. A read in this cycle frees a slot that becomes usable next cycle.
- Empty: oValid 0; iReady is ignored and count never underflows.
- Simultaneous write+read with 0 < count < DEPTH: both complete and count holds.
- iMode is sampled only with a write. Mode changes between operands are allowed every cycle.

Outputs:
- oFull, oEmpty and oCount derive from the registered count only.

Test Plan:
1. Reset, then single writes, one per mode (iReady=1):
   - iA=16'h8000, iMode=00 -> oB=32'h00008000.
   - iMode=01 -> 32'hFFFF8000.
   - iMode=10 -> 32'h80000000.
   - iMode=11 -> 32'hFFFF8000.
   - Each appears one cycle after its write.
2. Fill with iReady=0:
   - Write 16'h0001..16'h0004 with iMode=00 -> oCount=4, oFull=1, oReady=0.
   - A 5th operand 16'h0005 is held off and not stored.
   - Set iReady=1 -> outputs 1,2,3,4 in order, then oEmpty=1, oValid=0.
3. Streaming at full rate (iValid=1, iReady=1):
   - 16'h7FFF with iMode=01, repeated 10 times -> oB=32'h00007FFF every cycle after the first.
   - oCount stays 1; pointers wrap at least twice with no loss or duplication.
4. Simultaneous at full:
   - count=4, iValid=1, iReady=1 -> read only, count=3, oReady=1 next cycle.
   - Next cycle write+read -> count stays 3.
5. Reset mid-operation:
   - count=3, assert iRst_n=0 between edges -> oValid=0, oCount=0 immediately.
   - After release, write 16'hFFFF with iMode=00 -> oB=32'h0000FFFF is the only output.
6. Parameter override IN_WIDTH=8, OUT_WIDTH=12, DEPTH=3:
   - iA=8'h80, iMode=01 -> 12'hF80; iMode=10 -> 12'h800.
   - Three writes set oFull=1; pointer wrap 2->0 is verified.

Source files
------------

// File: rtl/extend_stream.sv
`default_nettype none
// ============================================================================
// Module   : extend_stream
// Brief    : Buffered operand extender. Accepts IN_WIDTH-bit operands on a
//            valid/ready stream, extends each to OUT_WIDTH bits (zero, sign,
//            upper-place or ones) and queues the result in a DEPTH-entry FIFO
//            presented on a valid/ready output stream.
// Revision : 1.0 - initial release
// ============================================================================
module extend_stream #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 32,
    parameter int DEPTH     = 4,
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic                 iClk,
    input  logic                 iRst_n,
    input  logic [IN_WIDTH-1:0]  iA,
    input  logic [1:0]           iMode,
    input  logic                 iValid,
    output logic                 oReady,
    output logic [OUT_WIDTH-1:0] oB,
    output logic                 oValid,
    input  logic                 iReady,
    output logic [CW-1:0]        oCount,
    output logic                 oFull,
    output logic                 oEmpty
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_PAD_W = OUT_WIDTH - IN_WIDTH;
    localparam int c_PTR_W = $clog2(DEPTH);

    localparam logic [c_PTR_W-1:0] c_LAST_PTR = c_PTR_W'(DEPTH - 1);
    localparam logic [CW-1:0]      c_DEPTH    = CW'(DEPTH);

    localparam logic [1:0] c_MODE_ZERO  = 2'b00;
    localparam logic [1:0] c_MODE_SIGN  = 2'b01;
    localparam logic [1:0] c_MODE_UPPER = 2'b10;
    localparam logic [1:0] c_MODE_ONES  = 2'b11;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [OUT_WIDTH-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wrPtr;
    logic [c_PTR_W-1:0]   r_rdPtr;
    logic [CW-1:0]        r_count;

    logic [OUT_WIDTH-1:0] w_extended;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_ready;
    logic                 w_valid;
    logic                 w_write;
    logic                 w_read;

    // ------------------------------------------------------------------------
    // Status flags come from the registered count only, so oReady never has
    // a combinational path from iReady.
    // ------------------------------------------------------------------------
    assign w_full  = (r_count == c_DEPTH);
    assign w_empty = (r_count == '0);
    assign w_ready = !w_full;
    assign w_valid = !w_empty;

    // A full FIFO ignores iValid; an empty FIFO ignores iReady.
    assign w_write = iValid && w_ready;
    assign w_read  = w_valid && iReady;

    // Extend the incoming operand; the stored FIFO entry is already extended.
    always_comb begin
        w_extended = {{c_PAD_W{1'b0}}, iA};
        case (iMode)
            c_MODE_ZERO:  w_extended = {{c_PAD_W{1'b0}}, iA};
            c_MODE_SIGN:  w_extended = {{c_PAD_W{iA[IN_WIDTH-1]}}, iA};
            c_MODE_UPPER: w_extended = {iA, {c_PAD_W{1'b0}}};
            c_MODE_ONES:  w_extended = {{c_PAD_W{1'b1}}, iA};
            default:      w_extended = {{c_PAD_W{1'b0}}, iA};
        endcase
    end

    // Storage array: written on an accepted operand, never reset.
    always_ff @(posedge iClk) begin
        if (w_write) begin
            r_mem[r_wrPtr] <= w_extended;
        end
    end

    // Write pointer advances per accepted operand, wrapping at DEPTH-1.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_wrPtr <= '0;
        end else if (w_write) begin
            if (r_wrPtr == c_LAST_PTR) begin
                r_wrPtr <= '0;
            end else begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
        end
    end

    // Read pointer advances per consumed result, wrapping at DEPTH-1.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_rdPtr <= '0;
        end else if (w_read) begin
            if (r_rdPtr == c_LAST_PTR) begin
                r_rdPtr <= '0;
            end else begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
        end
    end

    // Occupancy: +1 on write only, -1 on read only, hold on both or neither.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_count <= '0;
        end else begin
            case ({w_write, w_read})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs. The head entry is masked to zero when nothing is stored so that
    // stale memory contents never leak onto oB (including right after reset).
    // ------------------------------------------------------------------------
    assign oReady = w_ready;
    assign oValid = w_valid;
    assign oB     = w_valid ? r_mem[r_rdPtr] : '0;
    assign oCount = r_count;
    assign oFull  = w_full;
    assign oEmpty = w_empty;

endmodule
`default_nettype wire

// File: tb/tb_extend_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_extend_stream
// Brief    : Directed self-checking bench for extend_stream. One instance at
//            the default 16->32 / depth 4, one at 8->12 / depth 3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_extend_stream;

    logic        iClk;
    logic        iRst_n;

    // Default-parameter instance
    logic [15:0] a0;
    logic [1:0]  mode0;
    logic        valid0;
    logic        ready0;
    logic [31:0] b0;
    logic        outValid0;
    logic        consReady0;
    logic [2:0]  count0;
    logic        full0;
    logic        empty0;

    // Overridden-parameter instance
    logic [7:0]  a1;
    logic [1:0]  mode1;
    logic        valid1;
    logic        ready1;
    logic [11:0] b1;
    logic        outValid1;
    logic        consReady1;
    logic [1:0]  count1;
    logic        full1;
    logic        empty1;

    int nChecks;
    int nErrors;

    extend_stream u_dut0 (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .iA     (a0),
        .iMode  (mode0),
        .iValid (valid0),
        .oReady (ready0),
        .oB     (b0),
        .oValid (outValid0),
        .iReady (consReady0),
        .oCount (count0),
        .oFull  (full0),
        .oEmpty (empty0)
    );

    extend_stream #(
        .IN_WIDTH  (8),
        .OUT_WIDTH (12),
        .DEPTH     (3)
    ) u_dut1 (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .iA     (a1),
        .iMode  (mode1),
        .iValid (valid1),
        .oReady (ready1),
        .oB     (b1),
        .oValid (outValid1),
        .iReady (consReady1),
        .oCount (count1),
        .oFull  (full1),
        .oEmpty (empty1)
    );

    initial begin
        iClk = 1'b0;
        forever #5 iClk = ~iClk;
    end

    // Single comparison point for the whole bench.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic checkEmpty0(input string tag);
        check({tag, ".valid"}, {31'd0, outValid0}, 32'd0);
        check({tag, ".empty"}, {31'd0, empty0},    32'd1);
        check({tag, ".count"}, {29'd0, count0},    32'd0);
        check({tag, ".b"},     b0,                 32'd0);
    endtask

    // Expected outputs for test 1 (iA = 16'h8000)
    logic [31:0] modeExp [4];

    initial begin
        nChecks    = 0;
        nErrors    = 0;
        iRst_n     = 1'b0;
        a0         = '0;
        mode0      = 2'b00;
        valid0     = 1'b0;
        consReady0 = 1'b0;
        a1         = '0;
        mode1      = 2'b00;
        valid1     = 1'b0;
        consReady1 = 1'b0;
        modeExp[0] = 32'h0000_8000;
        modeExp[1] = 32'hFFFF_8000;
        modeExp[2] = 32'h8000_0000;
        modeExp[3] = 32'hFFFF_8000;

        // ---------------- Reset state ----------------
        #12;
        checkEmpty0("rst");
        check("rst.full",  {31'd0, full0},  32'd0);
        check("rst.ready", {31'd0, ready0}, 32'd1);
        check("rst.b1",    {20'd0, b1},     32'd0);
        #10 iRst_n = 1'b1;
        step();
        checkEmpty0("postRst");

        // ---------------- Test 1: one write per mode ----------------
        consReady0 = 1'b1;
        for (int m = 0; m < 4; m++) begin
            a0     = 16'h8000;
            mode0  = 2'(m);
            valid0 = 1'b1;
            step();
            valid0 = 1'b0;
            check($sformatf("t1.b.m%0d", m),     b0,                 modeExp[m]);
            check($sformatf("t1.valid.m%0d", m), {31'd0, outValid0}, 32'd1);
            check($sformatf("t1.count.m%0d", m), {29'd0, count0},    32'd1);
        end
        step();
        checkEmpty0("t1.drain");

        // ---------------- Test 2: fill with consumer stalled ----------------
        consReady0 = 1'b0;
        mode0      = 2'b00;
        for (int k = 1; k <= 4; k++) begin
            a0     = 16'(k);
            valid0 = 1'b1;
            step();
        end
        check("t2.count", {29'd0, count0}, 32'd4);
        check("t2.full",  {31'd0, full0},  32'd1);
        check("t2.ready", {31'd0, ready0}, 32'd0);
        a0 = 16'h0005;
        step();
        step();
        valid0 = 1'b0;
        check("t2.heldCount", {29'd0, count0}, 32'd4);
        check("t2.heldHead",  b0,              32'h0000_0001);
        consReady0 = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("t2.out%0d", k), b0, 32'(k));
            step();
        end
        checkEmpty0("t2.drain");

        // ---------------- Test 3: full-rate streaming ----------------
        a0     = 16'h7FFF;
        mode0  = 2'b01;
        valid0 = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            check($sformatf("t3.b%0d", k),     b0,              32'h0000_7FFF);
            check($sformatf("t3.count%0d", k), {29'd0, count0}, 32'd1);
        end
        valid0 = 1'b0;
        step();
        checkEmpty0("t3.drain");

        // Distinct values expose loss or duplication across pointer wraps.
        mode0  = 2'b00;
        valid0 = 1'b1;
        for (int k = 0; k < 10; k++) begin
            a0 = 16'h0100 + 16'(k);
            step();
            check($sformatf("t3.seq%0d", k), b0, 32'h0000_0100 + 32'(k));
        end
        valid0 = 1'b0;
        step();
        checkEmpty0("t3.seqDrain");

        // ---------------- Test 4: write+read at full ----------------
        consReady0 = 1'b0;
        mode0      = 2'b11;
        valid0     = 1'b1;
        for (int k = 0; k < 4; k++) begin
            a0 = 16'h000A + 16'(k);
            step();
        end
        check("t4.full", {31'd0, full0}, 32'd1);
        a0         = 16'h000E;
        consReady0 = 1'b1;
        step();
        check("t4.readOnlyCount", {29'd0, count0}, 32'd3);
        check("t4.readyBack",     {31'd0, ready0}, 32'd1);
        check("t4.headB",         b0,              32'hFFFF_000B);
        step();
        valid0 = 1'b0;
        check("t4.bothCount", {29'd0, count0}, 32'd3);
        check("t4.headC",     b0,              32'hFFFF_000C);
        step();
        check("t4.headD", b0, 32'hFFFF_000D);
        step();
        check("t4.headE", b0, 32'hFFFF_000E);
        step();
        checkEmpty0("t4.drain");

        // ---------------- Test 5: reset mid-operation ----------------
        consReady0 = 1'b0;
        mode0      = 2'b00;
        valid0     = 1'b1;
        for (int k = 0; k < 3; k++) begin
            a0 = 16'h0050 + 16'(k);
            step();
        end
        valid0 = 1'b0;
        check("t5.preCount", {29'd0, count0}, 32'd3);
        #2 iRst_n = 1'b0;
        #1;
        checkEmpty0("t5.asyncRst");
        #2 iRst_n = 1'b1;
        a0     = 16'hFFFF;
        mode0  = 2'b00;
        valid0 = 1'b1;
        step();
        valid0 = 1'b0;
        check("t5.b",     b0,              32'h0000_FFFF);
        check("t5.count", {29'd0, count0}, 32'd1);
        consReady0 = 1'b1;
        step();
        checkEmpty0("t5.only");

        // ---------------- Test 6: 8 -> 12, depth 3 ----------------
        consReady1 = 1'b0;
        valid1     = 1'b1;
        a1         = 8'h80;
        mode1      = 2'b01;
        step();
        check("t6.sign", {20'd0, b1}, 32'h0000_0F80);
        mode1 = 2'b10;
        step();
        check("t6.headHold", {20'd0, b1},     32'h0000_0F80);
        check("t6.count2",   {30'd0, count1}, 32'd2);
        a1    = 8'h12;
        mode1 = 2'b00;
        step();
        valid1 = 1'b0;
        check("t6.full",  {31'd0, full1},  32'd1);
        check("t6.count", {30'd0, count1}, 32'd3);
        check("t6.ready", {31'd0, ready1}, 32'd0);
        consReady1 = 1'b1;
        step();
        consReady1 = 1'b0;
        check("t6.upper",     {20'd0, b1},     32'h0000_0800);
        check("t6.afterRead", {30'd0, count1}, 32'd2);
        a1     = 8'h34;
        mode1  = 2'b11;
        valid1 = 1'b1;
        step();
        valid1 = 1'b0;
        check("t6.refull", {31'd0, full1}, 32'd1);
        consReady1 = 1'b1;
        check("t6.out800", {20'd0, b1}, 32'h0000_0800);
        step();
        check("t6.out012", {20'd0, b1}, 32'h0000_0012);
        step();
        check("t6.wrapF34", {20'd0, b1}, 32'h0000_0F34);
        step();
        check("t6.empty", {31'd0, empty1},    32'd1);
        check("t6.valid", {31'd0, outValid1}, 32'd0);
        check("t6.b0",    {20'd0, b1},        32'd0);

        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule
`default_nettype wire
